bo_datapath: RTL and testbench
==============================

# bo_datapath

Datapath for the multi-cycle arithmetic unit. It is driven cycle by cycle by the `BO` control FSM through the load strobes `LX`/`LS`/`LH`, the mux selects `M0`/`M1`/`M2` and the ALU select `SEL_ULA`. It holds the three working registers X, S and H, computes one ALU operation per cycle, and returns registered condition flags plus an X-is-zero status that the FSM uses for loop and termination decisions.

## Interface
- `WIDTH`, default 8: width of the data path, the registers and the ALU.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `LX`, `LS`, `LH`  in  1 each  load enables for registers X, S and H.
- `SEL_ULA`  in  1  ALU operation select: 1 = add (A+B), 0 = subtract (A−B).
- `M0`  in  2  ALU operand A select: 00 X, 01 S, 10 H, 11 `DIN`.
- `M1`  in  2  ALU operand B select: 00 X, 01 H, 10 constant 1, 11 `DIN`.
- `M2`  in  2  write-back source: 00 ALU result, 01 `DIN`, 10 zero, 11 ALU result shifted left by 1 (LSB filled with 0).
- `DIN`  in  WIDTH  external operand.
- `X`, `S`, `H`  out  WIDTH each  register contents.
- `Z`, `N`, `C`, `V`  out  1 each  registered flags: zero, negative, carry/no-borrow, signed overflow.
- `XZ`  out  1  combinational, equals 1 when X == 0.

## Operation
- **ALU.** The ALU is combinational on the current register values and `DIN`, all WIDTH bits.
- **Add.** R = A + B computed modulo 2^WIDTH. C is the carry out. V = (A[msb] == B[msb]) && (R[msb] != A[msb]).
- **Subtract.** R = A − B computed as A + ~B + 1. C = 1 means no borrow (A ≥ B unsigned). V = (A[msb] != B[msb]) && (R[msb] != A[msb]).
- **Flags from R.** Z = (R == 0). N = R[msb].
- **Write-back.** The value selected by `M2` goes to every register whose load strobe is high. Several strobes may be high in the same cycle; all selected registers receive the same value.
- **Read-modify-write.** Uses the old register values. For example, X ← X + H in one cycle with `LX` = 1 is legal.
- **Flag capture.**
  - Z, N, C and V are captured from the ALU only on cycles where at least one of `LX`/`LS`/`LH` is high. Otherwise they hold.
  - Flags always describe R, even when `M2` selects `DIN` or zero.
  - For `M2` = 11, C and V still describe R, not the shifted value.
- **Idle cycles.** When no load strobe is high, the values of `M0`, `M1`, `M2` and `SEL_ULA` are don't-care, including X or undefined values from the controller. Registers and flags are unaffected.
- **No internal FSM.** All sequencing is owned by the controller.

## Timing
- **Reset.** `RST` = 1 at a rising edge gives X = S = H = 0 and Z = N = C = V = 0. XZ = 1 immediately after that edge.
- **Reset priority.** Reset overrides any simultaneous load strobes. A reset in the middle of a controller sequence aborts it with no partial update.
- **Load latency.** A strobe sampled at edge k gives the new register value visible after edge k, that is, one cycle of latency. Flags update on the same edge.
- **XZ path.** XZ follows X combinationally, so the controller sees it in the cycle after X is loaded.
- **Critical path.** The longest path is mux → adder → M2 mux → register, and it must close within one `clk` period.

## Test plan
- **Reset.** Hold `RST` = 1 for one edge with `LX` = `LS` = `LH` = 1 and `M2` = 01, `DIN` = 0xAA. Required: X = S = H = 0x00, all flags 0, XZ = 1.
- **External load.** `DIN` = 0x05, `M2` = 01, `LX` = 1 for one cycle. Required: X = 0x05, S and H unchanged, XZ = 0.
- **Controller pattern.** Start from X = 0x05, H = 0x03. Apply `LX` = `LH` = 1, `M0` = 00, `M1` = 01, `M2` = 00, `SEL_ULA` = 1. Required: X = H = 0x08 after one edge, Z = 0, C = 0, V = 0.
- **Wrap and overflow.**
  - X = 0x7F, `M1` = 10, add, `LS` = 1. Required: S = 0x80, N = 1, V = 1, C = 0.
  - Then X = 0xFF, add 1. Required: S = 0x00, Z = 1, C = 1, V = 0.
- **Subtract and shift.**
  - X = 0x03, H = 0x05, `SEL_ULA` = 0, `M0` = 00, `M1` = 01, `M2` = 00, `LS` = 1. Required: S = 0xFE, N = 1, C = 0.
  - Same operands with `M2` = 11. Required: S = 0xFC.
- **Idle hold and mid-sequence reset.**
  - All strobes low with `M0`/`M1`/`M2` = X for 3 cycles. Required: registers and flags unchanged.
  - Then assert `RST` during an `LX` cycle. Required: X = 0x00.

Source files
------------

// File: rtl/bo_datapath_if.sv
// Control/status bundle between the BO controller (master) and the datapath (slave).
interface bo_datapath_if #(parameter int WIDTH = 8);
    logic             LX, LS, LH;
    logic             SEL_ULA;
    logic [1:0]       M0, M1, M2;
    logic [WIDTH-1:0] DIN;
    logic [WIDTH-1:0] X, S, H;
    logic             Z, N, C, V;
    logic             XZ;

    modport master (
        output LX, LS, LH, SEL_ULA, M0, M1, M2, DIN,
        input  X, S, H, Z, N, C, V, XZ
    );

    modport slave (
        input  LX, LS, LH, SEL_ULA, M0, M1, M2, DIN,
        output X, S, H, Z, N, C, V, XZ
    );
endinterface

// File: rtl/bo_datapath.sv
// Working registers X/S/H, single-cycle add/sub ALU, write-back mux and
// registered flags for the multi-cycle arithmetic unit.
module bo_datapath #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         RST,
    bo_datapath_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] r_x, r_s, r_h;
    logic             r_z, r_n, r_c, r_v;

    logic [WIDTH-1:0] w_a, w_b, w_bop, w_r, w_wb;
    logic             w_cout, w_v, w_ld;

    assign w_ld = bus.LX | bus.LS | bus.LH;

    always_comb begin
        case (bus.M0)
            2'b00:   w_a = r_x;
            2'b01:   w_a = r_s;
            2'b10:   w_a = r_h;
            default: w_a = bus.DIN;
        endcase
        case (bus.M1)
            2'b00:   w_b = r_x;
            2'b01:   w_b = r_h;
            2'b10:   w_b = {{(WIDTH-1){1'b0}}, 1'b1};
            default: w_b = bus.DIN;
        endcase
    end

    // Subtract is A + ~B + 1, so the carry out doubles as "no borrow".
    assign w_bop = bus.SEL_ULA ? w_b : ~w_b;
    assign {w_cout, w_r} = {1'b0, w_a} + {1'b0, w_bop}
                         + {{WIDTH{1'b0}}, ~bus.SEL_ULA};
    assign w_v = bus.SEL_ULA
               ? ((w_a[MSB] == w_b[MSB]) && (w_r[MSB] != w_a[MSB]))
               : ((w_a[MSB] != w_b[MSB]) && (w_r[MSB] != w_a[MSB]));

    always_comb begin
        case (bus.M2)
            2'b00:   w_wb = w_r;
            2'b01:   w_wb = bus.DIN;
            2'b10:   w_wb = '0;
            default: w_wb = {w_r[WIDTH-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_x <= '0;
            r_s <= '0;
            r_h <= '0;
            r_z <= 1'b0;
            r_n <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else begin
            if (bus.LX) r_x <= w_wb;
            if (bus.LS) r_s <= w_wb;
            if (bus.LH) r_h <= w_wb;
            // Flags always describe the raw ALU result, whatever M2 selects.
            if (w_ld) begin
                r_z <= (w_r == '0);
                r_n <= w_r[MSB];
                r_c <= w_cout;
                r_v <= w_v;
            end
        end
    end

    assign bus.X  = r_x;
    assign bus.S  = r_s;
    assign bus.H  = r_h;
    assign bus.Z  = r_z;
    assign bus.N  = r_n;
    assign bus.C  = r_c;
    assign bus.V  = r_v;
    assign bus.XZ = (r_x == '0);
endmodule

// File: tb/tb_bo_datapath.sv
// Self-checking bench: directed test-plan steps then random cycles against an arithmetic model.
module tb_bo_datapath;
    localparam int W = 8;

    logic clk = 1'b0;
    logic RST;
    int   n_tot = 0;
    int   n_bad = 0;

    bo_datapath_if #(.WIDTH(W)) bus ();

    bo_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    int mx, ms, mh;
    bit mz, mn, mc, mv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int u);
        return (u >= 128) ? u - 256 : u;
    endfunction

    task automatic step_model();
        int a, b, r, sr, wb;
        if (RST) begin
            mx = 0; ms = 0; mh = 0;
            mz = 0; mn = 0; mc = 0; mv = 0;
        end else if (bus.LX || bus.LS || bus.LH) begin
            case (bus.M0)
                2'd0: a = mx;
                2'd1: a = ms;
                2'd2: a = mh;
                default: a = int'(bus.DIN);
            endcase
            case (bus.M1)
                2'd0: b = mx;
                2'd1: b = mh;
                2'd2: b = 1;
                default: b = int'(bus.DIN);
            endcase
            if (bus.SEL_ULA) begin
                r  = a + b;
                mc = (r > 255);
                sr = sgn(a) + sgn(b);
            end else begin
                r  = a - b;
                mc = (a >= b);
                sr = sgn(a) - sgn(b);
            end
            mv = (sr > 127) || (sr < -128);
            r  = r & 255;
            mz = (r == 0);
            mn = (r >= 128);
            case (bus.M2)
                2'd0: wb = r;
                2'd1: wb = int'(bus.DIN);
                2'd2: wb = 0;
                default: wb = (r * 2) & 255;
            endcase
            if (bus.LX) mx = wb;
            if (bus.LS) ms = wb;
            if (bus.LH) mh = wb;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".X"},  32'(bus.X),  32'(mx));
        chk({tag, ".S"},  32'(bus.S),  32'(ms));
        chk({tag, ".H"},  32'(bus.H),  32'(mh));
        chk({tag, ".Z"},  32'(bus.Z),  32'(mz));
        chk({tag, ".N"},  32'(bus.N),  32'(mn));
        chk({tag, ".C"},  32'(bus.C),  32'(mc));
        chk({tag, ".V"},  32'(bus.V),  32'(mv));
        chk({tag, ".XZ"}, 32'(bus.XZ), 32'(mx == 0));
    endtask

    task automatic tick(input string tag);
        step_model();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drv(input bit lx, input bit ls, input bit lh, input bit sel,
                       input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                       input logic [7:0] din);
        bus.LX = lx; bus.LS = ls; bus.LH = lh; bus.SEL_ULA = sel;
        bus.M0 = m0; bus.M1 = m1; bus.M2 = m2; bus.DIN = din;
    endtask

    initial begin
        // Reset with every strobe high and DIN on the write-back path
        RST = 1'b1;
        drv(1, 1, 1, 1, 2'd3, 2'd3, 2'd1, 8'hAA);
        tick("reset");
        chk("reset_xz", 32'(bus.XZ), 32'd1);

        RST = 1'b0;
        drv(1, 0, 0, 1, 2'd0, 2'd0, 2'd1, 8'h05);
        tick("load");
        chk("load_x", 32'(bus.X), 32'h05);
        chk("load_xz", 32'(bus.XZ), 32'd0);

        drv(0, 0, 1, 1, 2'd0, 2'd0, 2'd1, 8'h03);
        tick("load_h");
        drv(1, 0, 1, 1, 2'd0, 2'd1, 2'd0, 8'h00);
        tick("ctl");
        chk("ctl_x", 32'(bus.X), 32'h08);
        chk("ctl_h", 32'(bus.H), 32'h08);
        chk("ctl_zcv", {29'd0, bus.Z, bus.C, bus.V}, 32'd0);

        drv(1, 0, 0, 1, 2'd0, 2'd0, 2'd1, 8'h7F);
        tick("ld7f");
        drv(0, 1, 0, 1, 2'd0, 2'd2, 2'd0, 8'h00);
        tick("ovf");
        chk("ovf_s", 32'(bus.S), 32'h80);
        chk("ovf_nvc", {29'd0, bus.N, bus.V, bus.C}, 32'b110);

        drv(1, 0, 0, 1, 2'd0, 2'd0, 2'd1, 8'hFF);
        tick("ldff");
        drv(0, 1, 0, 1, 2'd0, 2'd2, 2'd0, 8'h00);
        tick("wrap");
        chk("wrap_s", 32'(bus.S), 32'h00);
        chk("wrap_zcv", {29'd0, bus.Z, bus.C, bus.V}, 32'b110);

        drv(1, 0, 0, 1, 2'd0, 2'd0, 2'd1, 8'h03);
        tick("ld3");
        drv(0, 0, 1, 1, 2'd0, 2'd0, 2'd1, 8'h05);
        tick("ld5");
        drv(0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 8'h00);
        tick("sub");
        chk("sub_s", 32'(bus.S), 32'hFE);
        chk("sub_nc", {30'd0, bus.N, bus.C}, 32'b10);
        drv(0, 1, 0, 0, 2'd0, 2'd1, 2'd3, 8'h00);
        tick("shl");
        chk("shl_s", 32'(bus.S), 32'hFC);

        bus.LX = 0; bus.LS = 0; bus.LH = 0;
        bus.SEL_ULA = 1'bx; bus.M0 = 2'bxx; bus.M1 = 2'bxx; bus.M2 = 2'bxx; bus.DIN = 8'hxx;
        for (int i = 0; i < 3; i++) tick("idle");
        chk("idle_s", 32'(bus.S), 32'hFC);

        drv(1, 0, 0, 1, 2'd0, 2'd0, 2'd1, 8'h5A);
        RST = 1'b1;
        tick("midrst");
        chk("midrst_x", 32'(bus.X), 32'h00);
        RST = 1'b0;

        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 24) == 0);
            drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
